// File: rtl/i_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Frame: sync, length (hi/lo), payload, checksum.
package i_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int IDX_W  = 16;
  localparam int SUM_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s inside {LEN_HI, LEN_LO, DATA, CSUM};
  endfunction

  // States in which a sync byte may start a new frame
  function automatic logic is_rest(input state_t s);
    return s inside {IDLE, DONE, ERR};
  endfunction

endpackage

// File: rtl/i_loader_if.sv
// Byte stream from the UART receiver plus the
// instruction memory write port driven by the loader.
interface i_loader_if #(
  parameter int addr_width = 16
) ();
  import i_loader_pkg::*;

  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_valid;
  logic [addr_width-1:0] w_addr;
  logic [BYTE_W-1:0]     din;
  logic                  w_en;

  modport master (
    input  rx_data,
    input  rx_valid,
    output w_addr,
    output din,
    output w_en
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  w_addr,
    input  din,
    input  w_en
  );

endinterface

// File: rtl/i_loader_timer.sv
// Inter-byte timeout counter: counts idle cycles while
// running, flags the cycle in which the limit is reached.
module i_loader_timer #(
  parameter int timeout_cycles = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW =
    (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(timeout_cycles - 2);

  logic [CW-1:0] cnt_q;

  // The count steps to timeout_cycles-1 on this edge
  assign expired = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/i_loader.sv
// Serial program loader: parses framed images from the UART,
// writes the payload to instruction memory, gates CPU reset.
module i_loader
  import i_loader_pkg::*;
#(
  parameter int                    addr_width     = 16,
  parameter int                    data_width     = 8,
  parameter logic [addr_width-1:0] base_addr      = '0,
  parameter int                    timeout_cycles = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  i_loader_if.master bus,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_t state_q;
  state_t state_d;

  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_full;
  logic [IDX_W-1:0]      idx_q;
  logic [data_width-1:0] sum_q;
  logic [data_width-1:0] sum_nx;

  logic sync_hit;
  logic last_byte;
  logic expired;
  logic run;
  logic clear;

  logic [addr_width-1:0] w_addr_q;
  logic [addr_width-1:0] w_addr_d;
  logic [data_width-1:0] din_q;
  logic [data_width-1:0] din_d;
  logic                  w_en_q;
  logic                  w_en_d;
  logic                  cpu_rst_q;
  logic                  cpu_rst_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  done_q;
  logic                  done_d;
  logic                  error_q;
  logic                  error_d;

  assign len_full  = {len_q[LEN_W-1:8], bus.rx_data};
  assign last_byte = idx_q == (len_q - LEN_W'(1));
  assign sum_nx    = sum_q + bus.rx_data;
  assign sync_hit  = bus.rx_valid
                  && (bus.rx_data == SYNC_BYTE);

  assign run   = is_busy(state_q);
  assign clear = bus.rx_valid || (state_d != state_q);

  i_loader_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .run    (run),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_addr_q  <= '0;
      din_q     <= '0;
      w_en_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_addr_q  <= w_addr_d;
      din_q     <= din_d;
      w_en_q    <= w_en_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // A byte always beats a timeout landing in the same cycle
  always_comb begin
    state_d = state_q;
    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (sync_hit) state_d = LEN_HI;
        end
        LEN_HI: state_d = LEN_LO;
        LEN_LO: begin
          state_d = (len_full == '0) ? CSUM : DATA;
        end
        DATA: begin
          if (last_byte) state_d = CSUM;
        end
        CSUM: begin
          state_d = (sum_nx == '0) ? DONE : ERR;
        end
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      state_d = ERR;
    end
  end

  always_comb begin
    busy_d    = is_busy(state_d);
    done_d    = state_d == DONE;
    error_d   = state_d == ERR;
    cpu_rst_d = state_d != DONE;
    w_en_d    = bus.rx_valid && (state_q == DATA);
    w_addr_d  = w_addr_q;
    din_d     = din_q;
    if (w_en_d) begin
      w_addr_d = base_addr + addr_width'(idx_q);
      din_d    = bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
    end else if (bus.rx_valid) begin
      unique case (1'b1)
        is_rest(state_q) && sync_hit: begin
          idx_q <= '0;
          sum_q <= '0;
        end
        state_q == LEN_HI: begin
          len_q[LEN_W-1:8] <= bus.rx_data;
        end
        state_q == LEN_LO: begin
          len_q[7:0] <= bus.rx_data;
        end
        state_q == DATA: begin
          sum_q <= sum_nx;
          idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.w_addr = w_addr_q;
  assign bus.din    = din_q;
  assign bus.w_en   = w_en_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_i_loader.sv
// Scoreboard bench for i_loader: two instances, one at base 0,
// one at base FFFE, both with a 16-cycle byte timeout.
module tb_i_loader;
  import i_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic       rxv  = 1'b0;
  logic [7:0] rxd  = 8'h00;
  int         sel  = 0;

  i_loader_if #(.addr_width(16)) bus0 ();
  i_loader_if #(.addr_width(16)) bus1 ();

  assign bus0.rx_data  = rxd;
  assign bus0.rx_valid = rxv && (sel == 0);
  assign bus1.rx_data  = rxd;
  assign bus1.rx_valid = rxv && (sel == 1);

  logic cpu_rst0, busy0, done0, error0;
  logic cpu_rst1, busy1, done1, error1;

  i_loader #(
    .addr_width(16), .data_width(8),
    .base_addr(16'h0000), .timeout_cycles(16)
  ) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0),
    .cpu_rst(cpu_rst0), .busy(busy0),
    .done(done0), .error(error0)
  );

  i_loader #(
    .addr_width(16), .data_width(8),
    .base_addr(16'hFFFE), .timeout_cycles(16)
  ) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .cpu_rst(cpu_rst1), .busy(busy1),
    .done(done1), .error(error1)
  );

  typedef struct {
    int         cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        q0[$];
  wr_t        q1[$];
  logic [7:0] pl[$];
  logic [15:0] widx;
  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus0.w_en === 1'b1) begin
      n_chk = n_chk + 1;
      if (q0.size() == 0) begin
        $display("FAIL wr0_extra: got %h@%h want none",
                 bus0.din, bus0.w_addr);
      end else begin
        e = q0.pop_front();
        if (e.cyc == cyc_n && e.addr == bus0.w_addr
            && e.data == bus0.din)
          n_pass = n_pass + 1;
        else
          $display("FAIL wr0: got %h@%h c%0d want %h@%h c%0d",
                   bus0.din, bus0.w_addr, cyc_n,
                   e.data, e.addr, e.cyc);
      end
    end
    if (bus1.w_en === 1'b1) begin
      n_chk = n_chk + 1;
      if (q1.size() == 0) begin
        $display("FAIL wr1_extra: got %h@%h want none",
                 bus1.din, bus1.w_addr);
      end else begin
        e = q1.pop_front();
        if (e.cyc == cyc_n && e.addr == bus1.w_addr
            && e.data == bus1.din)
          n_pass = n_pass + 1;
        else
          $display("FAIL wr1: got %h@%h c%0d want %h@%h c%0d",
                   bus1.din, bus1.w_addr, cyc_n,
                   e.data, e.addr, e.cyc);
      end
    end
  end

  task automatic put(input logic v, input logic [7:0] d);
    @(negedge clk);
    rxv = v;
    rxd = d;
  endtask

  task automatic idle();
    put(1'b0, 8'h00);
  endtask

  task automatic put_data(input logic [7:0] d);
    wr_t e;
    @(negedge clk);
    rxv    = 1'b1;
    rxd    = d;
    e.cyc  = cyc_n + 1;
    e.addr = ((sel == 0) ? 16'h0000 : 16'hFFFE) + widx;
    e.data = d;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    widx = widx + 16'd1;
  endtask

  task automatic send_frame(input logic [7:0] cs);
    logic [15:0] len;
    len = 16'(pl.size());
    put(1'b1, 8'hA5);
    put(1'b1, len[15:8]);
    put(1'b1, len[7:0]);
    widx = 16'd0;
    foreach (pl[i]) put_data(pl[i]);
    put(1'b1, cs);
    idle();
  endtask

  task automatic st0(input string nm, input logic b,
                     input logic d, input logic e,
                     input logic c);
    check({nm, "_busy"},    32'(busy0),    32'(b));
    check({nm, "_done"},    32'(done0),    32'(d));
    check({nm, "_error"},   32'(error0),   32'(e));
    check({nm, "_cpu_rst"}, 32'(cpu_rst0), 32'(c));
  endtask

  task automatic st1(input string nm, input logic b,
                     input logic d, input logic e,
                     input logic c);
    check({nm, "_busy"},    32'(busy1),    32'(b));
    check({nm, "_done"},    32'(done1),    32'(d));
    check({nm, "_error"},   32'(error1),   32'(e));
    check({nm, "_cpu_rst"}, 32'(cpu_rst1), 32'(c));
  endtask

  initial begin
    widx = 16'd0;
    repeat (3) idle();
    st0("rst0", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst0_w_en",   32'(bus0.w_en),   32'd0);
    check("rst0_w_addr", 32'(bus0.w_addr), 32'd0);
    check("rst0_din",    32'(bus0.din),    32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Non-sync bytes in IDLE
    put(1'b1, 8'h00);
    put(1'b1, 8'hFF);
    idle();
    st0("ignore", 1'b0, 1'b0, 1'b0, 1'b1);
    check("ignore_state", 32'(dut0.state_q), 32'(IDLE));

    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h9A);
    st0("basic", 1'b0, 1'b1, 1'b0, 1'b0);

    pl = '{8'h10, 8'h20};
    send_frame(8'h00);
    st0("badcs", 1'b0, 1'b0, 1'b1, 1'b1);

    pl = '{8'h01};
    send_frame(8'hFF);
    st0("recover", 1'b0, 1'b1, 1'b0, 1'b0);

    pl.delete();
    send_frame(8'h00);
    st0("zlen_ok", 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h01);
    st0("zlen_bad", 1'b0, 1'b0, 1'b1, 1'b1);

    // 16 payload bytes on consecutive cycles
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'h40 + i));
    send_frame(8'h88);
    st0("b2b", 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b_q", 32'(q0.size()), 32'd0);

    // Sync in DONE reasserts CPU reset
    put(1'b1, 8'hA5);
    idle();
    st0("reload", 1'b1, 1'b0, 1'b0, 1'b1);
    put(1'b1, 8'h00);
    put(1'b1, 8'h00);
    put(1'b1, 8'h00);
    idle();
    st0("reload_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Timeout mid-payload
    put(1'b1, 8'hA5);
    put(1'b1, 8'h00);
    put(1'b1, 8'h04);
    widx = 16'd0;
    put_data(8'h01);
    repeat (15) idle();
    st0("to_wait", 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    st0("to_hit", 1'b0, 1'b0, 1'b1, 1'b1);
    check("to_state", 32'(dut0.state_q), 32'(ERR));
    put(1'b1, 8'h5A);
    idle();
    st0("to_stray", 1'b0, 1'b0, 1'b1, 1'b1);
    check("to_stray_state", 32'(dut0.state_q), 32'(ERR));
    put(1'b1, 8'hA5);
    idle();
    st0("to_resync", 1'b1, 1'b0, 1'b0, 1'b1);
    put(1'b1, 8'h00);
    put(1'b1, 8'h00);
    put(1'b1, 8'h00);
    idle();
    st0("to_end", 1'b0, 1'b1, 1'b0, 1'b0);
    check("q0_empty", 32'(q0.size()), 32'd0);

    // Address wrap and mid-frame reset on the FFFE instance
    sel = 1;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'hF6);
    st1("wrap", 1'b0, 1'b1, 1'b0, 1'b0);
    put(1'b1, 8'hA5);
    put(1'b1, 8'h00);
    put(1'b1, 8'h04);
    widx = 16'd0;
    put_data(8'hAA);
    put_data(8'hBB);
    idle();
    rst1 = 1'b1;
    idle();
    st1("midrst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_w_en",   32'(bus1.w_en),   32'd0);
    check("midrst_w_addr", 32'(bus1.w_addr), 32'd0);
    check("midrst_din",    32'(bus1.din),    32'd0);
    check("midrst_state",  32'(dut1.state_q), 32'(IDLE));
    rst1 = 1'b0;
    idle();
    check("q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
